// File: rtl/csr_file_pkg.sv
// Shared CSR address map, field bit positions and write-select bundle for csr_file.
package csr_file_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // mie / mip field positions (shared layout)
    localparam int IRQ_SW_BIT  = 3;
    localparam int IRQ_TIM_BIT = 7;
    localparam int IRQ_EXT_BIT = 11;

    // mtvec bit 1 is reserved mode encoding; mepc is always word aligned
    localparam logic [31:0] MTVEC_WMASK = ~32'h0000_0002;
    localparam logic [31:0] MEPC_WMASK  = ~32'h0000_0003;

    // One-hot software write selects, decoded once from waddr_i
    typedef struct packed {
        logic mstatus;
        logic mie;
        logic mtvec;
        logic mscratch;
        logic mepc;
        logic mcause;
        logic mtval;
        logic mcycle;
        logic mcycleh;
        logic minstret;
        logic minstreth;
    } csr_wsel_t;

    // Place the three interrupt bits at their architectural positions
    function automatic logic [31:0] pack_irq_bits(input logic ext, input logic tim, input logic sw);
        logic [31:0] v;
        v = '0;
        v[IRQ_EXT_BIT] = ext;
        v[IRQ_TIM_BIT] = tim;
        v[IRQ_SW_BIT]  = sw;
        return v;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes priority over the increment for that cycle,
// so no carry ripples across a half being loaded.
module csr_counter64
    import csr_file_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] q_o
);

    logic [63:0] r_q;

    // Load a half on write, otherwise count; wraps naturally at 2^64
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_q <= '0;
        end else if (we_lo_i) begin
            r_q[31:0] <= wdata_i;
        end else if (we_hi_i) begin
            r_q[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_q <= r_q + 64'd1;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file. Responds to trap-entry / mret updates from
// the trap controller, serves csrr/csrw traffic from ID/EX, and exports the
// interrupt-enable, pending, mtvec and mepc state back to the controller.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'h0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [11:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        irq_external_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    input  logic        instret_i,
    input  logic        ie_type_i,
    input  logic        set_cause_i,
    input  logic [3:0]  trap_cause_i,
    input  logic        set_epc_i,
    input  logic [31:0] epc_i,
    input  logic        set_mtval_i,
    input  logic [31:0] mtval_i,
    input  logic        mstatus_ie_clear_i,
    input  logic        mstatus_ie_set_i,
    output logic        mstatus_ie_o,
    output logic        mie_external_o,
    output logic        mie_timer_o,
    output logic        mie_sw_o,
    output logic        mip_external_o,
    output logic        mip_timer_o,
    output logic        mip_sw_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] epc_o
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_ext;
    logic        r_mie_tim;
    logic        r_mie_sw;
    logic        r_mip_ext;
    logic        r_mip_tim;
    logic        r_mip_sw;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    csr_wsel_t   w_wsel;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_rdata;

    // Decode the software write port; read-only and unknown addresses select nothing
    always_comb begin
        w_wsel = '0;
        if (we_i) begin
            case (waddr_i)
                CSR_MSTATUS:   w_wsel.mstatus   = 1'b1;
                CSR_MIE:       w_wsel.mie       = 1'b1;
                CSR_MTVEC:     w_wsel.mtvec     = 1'b1;
                CSR_MSCRATCH:  w_wsel.mscratch  = 1'b1;
                CSR_MEPC:      w_wsel.mepc      = 1'b1;
                CSR_MCAUSE:    w_wsel.mcause    = 1'b1;
                CSR_MTVAL:     w_wsel.mtval     = 1'b1;
                CSR_MCYCLE:    w_wsel.mcycle    = 1'b1;
                CSR_MCYCLEH:   w_wsel.mcycleh   = 1'b1;
                CSR_MINSTRET:  w_wsel.minstret  = 1'b1;
                CSR_MINSTRETH: w_wsel.minstreth = 1'b1;
                default:       w_wsel           = '0;
            endcase
        end
    end

    // mstatus: trap entry beats mret, and both beat a software write
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (mstatus_ie_clear_i) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mstatus_ie_set_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wsel.mstatus) begin
            r_mstatus_mie  <= wdata_i[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= wdata_i[MSTATUS_MPIE_BIT];
        end
    end

    // mie: only the three machine-level enables are stored
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mie_ext <= 1'b0;
            r_mie_tim <= 1'b0;
            r_mie_sw  <= 1'b0;
        end else if (w_wsel.mie) begin
            r_mie_ext <= wdata_i[IRQ_EXT_BIT];
            r_mie_tim <= wdata_i[IRQ_TIM_BIT];
            r_mie_sw  <= wdata_i[IRQ_SW_BIT];
        end
    end

    // mip: one flop per line; software cannot write pending bits
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mip_ext <= 1'b0;
            r_mip_tim <= 1'b0;
            r_mip_sw  <= 1'b0;
        end else begin
            r_mip_ext <= irq_external_i;
            r_mip_tim <= irq_timer_i;
            r_mip_sw  <= irq_sw_i;
        end
    end

    // mtvec and mscratch: software-only registers
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mtvec    <= '0;
            r_mscratch <= '0;
        end else begin
            if (w_wsel.mtvec) begin
                r_mtvec <= wdata_i & MTVEC_WMASK;
            end
            if (w_wsel.mscratch) begin
                r_mscratch <= wdata_i;
            end
        end
    end

    // mepc: trap load beats software write; always word aligned
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mepc <= '0;
        end else if (set_epc_i) begin
            r_mepc <= epc_i & MEPC_WMASK;
        end else if (w_wsel.mepc) begin
            r_mepc <= wdata_i & MEPC_WMASK;
        end
    end

    // mcause: trap load beats software write
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mcause <= '0;
        end else if (set_cause_i) begin
            r_mcause <= {ie_type_i, 27'b0, trap_cause_i};
        end else if (w_wsel.mcause) begin
            r_mcause <= wdata_i;
        end
    end

    // mtval: trap load beats software write
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mtval <= '0;
        end else if (set_mtval_i) begin
            r_mtval <= mtval_i;
        end else if (w_wsel.mtval) begin
            r_mtval <= wdata_i;
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .inc_i   (1'b1),
        .we_lo_i (w_wsel.mcycle),
        .we_hi_i (w_wsel.mcycleh),
        .wdata_i (wdata_i),
        .q_o     (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .inc_i   (instret_i),
        .we_lo_i (w_wsel.minstret),
        .we_hi_i (w_wsel.minstreth),
        .wdata_i (wdata_i),
        .q_o     (w_minstret)
    );

    // Read mux from current state; no bypass of an in-flight write
    always_comb begin
        w_rdata = '0;
        case (raddr_i)
            CSR_MSTATUS: begin
                w_rdata[MSTATUS_MIE_BIT]  = r_mstatus_mie;
                w_rdata[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
            end
            CSR_MISA:      w_rdata = MISA_VAL;
            CSR_MIE:       w_rdata = pack_irq_bits(r_mie_ext, r_mie_tim, r_mie_sw);
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MIP:       w_rdata = pack_irq_bits(r_mip_ext, r_mip_tim, r_mip_sw);
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:   w_rdata = HART_ID;
            default:       w_rdata = '0;
        endcase
    end

    // Constant CSRs would otherwise show through while reset is held
    assign rdata_o        = n_rst_i ? w_rdata : '0;

    assign mstatus_ie_o   = r_mstatus_mie;
    assign mie_external_o = r_mie_ext;
    assign mie_timer_o    = r_mie_tim;
    assign mie_sw_o       = r_mie_sw;
    assign mip_external_o = r_mip_ext;
    assign mip_timer_o    = r_mip_tim;
    assign mip_sw_o       = r_mip_sw;
    assign mtvec_o        = r_mtvec;
    assign epc_o          = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: reset-read table, directed corner
// sequences, then randomized traffic against an architectural model.
module tb_csr_file;

    localparam logic [31:0] TB_HART = 32'h0000_0005;
    localparam logic [31:0] TB_MISA = 32'h4000_0100;

    logic        clk;
    logic        n_rst;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        irq_ext, irq_tim, irq_sw;
    logic        instret;
    logic        ie_type;
    logic        set_cause;
    logic [3:0]  cause;
    logic        set_epc;
    logic [31:0] epc;
    logic        set_mtval;
    logic [31:0] mtval;
    logic        ie_clear, ie_set;
    logic        o_mie, o_meie, o_mtie, o_msie, o_meip, o_mtip, o_msip;
    logic [31:0] o_mtvec, o_epc;

    int n_cmp = 0;
    int n_bad = 0;

    csr_file #(.HART_ID(TB_HART), .MISA_VAL(TB_MISA)) dut (
        .clk_i              (clk),
        .n_rst_i            (n_rst),
        .raddr_i            (raddr),
        .rdata_o            (rdata),
        .we_i               (we),
        .waddr_i            (waddr),
        .wdata_i            (wdata),
        .irq_external_i     (irq_ext),
        .irq_timer_i        (irq_tim),
        .irq_sw_i           (irq_sw),
        .instret_i          (instret),
        .ie_type_i          (ie_type),
        .set_cause_i        (set_cause),
        .trap_cause_i       (cause),
        .set_epc_i          (set_epc),
        .epc_i              (epc),
        .set_mtval_i        (set_mtval),
        .mtval_i            (mtval),
        .mstatus_ie_clear_i (ie_clear),
        .mstatus_ie_set_i   (ie_set),
        .mstatus_ie_o       (o_mie),
        .mie_external_o     (o_meie),
        .mie_timer_o        (o_mtie),
        .mie_sw_o           (o_msie),
        .mip_external_o     (o_meip),
        .mip_timer_o        (o_mtip),
        .mip_sw_o           (o_msip),
        .mtvec_o            (o_mtvec),
        .epc_o              (o_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: named fields, counters as 64-bit integers
    logic        m_mie, m_mpie;
    logic [2:0]  m_en;    // {ext, tim, sw}
    logic [2:0]  m_pend;  // {ext, tim, sw}
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
    logic [63:0] m_cyc, m_ins;

    logic        n_mie, n_mpie;
    logic [2:0]  n_en, n_pend;
    logic [31:0] n_mtvec, n_mepc, n_mcause, n_mtval, n_mscratch;
    logic [63:0] n_cyc, n_ins;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_en = 0; m_pend = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] irq_word(input logic [2:0] b);
        return (b[2] ? 32'h800 : 32'h0) | (b[1] ? 32'h80 : 32'h0) | (b[0] ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (!n_rst) return 32'h0;
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: return TB_MISA;
            12'h304: return irq_word(m_en);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return irq_word(m_pend);
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF14: return TB_HART;
            default: return 32'h0;
        endcase
    endfunction

    // Next architectural state from the current inputs
    task automatic model_next();
        bit wr;
        n_mie = m_mie; n_mpie = m_mpie; n_en = m_en;
        n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
        n_mtval = m_mtval; n_mscratch = m_mscratch;
        n_pend = {irq_ext, irq_tim, irq_sw};
        if (ie_clear) begin
            n_mpie = m_mie; n_mie = 0;
        end else if (ie_set) begin
            n_mie = m_mpie; n_mpie = 1;
        end else if (we && waddr == 12'h300) begin
            n_mie = wdata[3]; n_mpie = wdata[7];
        end
        if (we && waddr == 12'h304) n_en = {wdata[11], wdata[7], wdata[3]};
        if (we && waddr == 12'h305) n_mtvec = wdata - (wdata % 4) + (wdata % 2);
        if (we && waddr == 12'h340) n_mscratch = wdata;
        if (set_epc) n_mepc = epc - (epc % 4);
        else if (we && waddr == 12'h341) n_mepc = wdata - (wdata % 4);
        if (set_cause) n_mcause = (ie_type ? 32'h8000_0000 : 32'h0) + 32'(cause);
        else if (we && waddr == 12'h342) n_mcause = wdata;
        if (set_mtval) n_mtval = mtval;
        else if (we && waddr == 12'h343) n_mtval = wdata;
        wr = 0;
        n_cyc = m_cyc + 1;
        if (we && waddr == 12'hB00) n_cyc = (m_cyc / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(wdata);
        if (we && waddr == 12'hB80) n_cyc = (64'(wdata) * 64'h1_0000_0000) + (m_cyc % 64'h1_0000_0000);
        n_ins = instret ? m_ins + 1 : m_ins;
        if (we && waddr == 12'hB02) begin n_ins = (m_ins / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(wdata); wr = 1; end
        if (we && waddr == 12'hB82) begin n_ins = (64'(wdata) * 64'h1_0000_0000) + (m_ins % 64'h1_0000_0000); wr = 1; end
        if (!n_rst) begin
            n_mie = 0; n_mpie = 0; n_en = 0; n_pend = 0; n_mtvec = 0; n_mepc = 0;
            n_mcause = 0; n_mtval = 0; n_mscratch = 0; n_cyc = 0; n_ins = 0;
        end
        if (wr && !n_rst) n_ins = n_ins;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_mie = n_mie; m_mpie = n_mpie; m_en = n_en; m_pend = n_pend;
        m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
        m_mtval = n_mtval; m_mscratch = n_mscratch; m_cyc = n_cyc; m_ins = n_ins;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic check_model();
        #1;
        chk("rdata_model", rdata, model_read(raddr));
        chk("flags_model", {25'b0, o_mie, o_meie, o_mtie, o_msie, o_meip, o_mtip, o_msip},
            {25'b0, m_mie, m_en, m_pend});
        chk("mtvec_model", o_mtvec, m_mtvec);
        chk("epc_model", o_epc, m_mepc);
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; instret = 0; ie_type = 0;
        set_cause = 0; cause = 0; set_epc = 0; epc = 0; set_mtval = 0; mtval = 0;
        ie_clear = 0; ie_set = 0;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[7];

    logic [11:0] addr_pool[15];
    logic [31:0] lo_before;

    initial begin
        vecs[0] = '{12'h300, 32'h0};
        vecs[1] = '{12'h304, 32'h0};
        vecs[2] = '{12'h305, 32'h0};
        vecs[3] = '{12'h341, 32'h0};
        vecs[4] = '{12'h342, 32'h0};
        vecs[5] = '{12'hF14, TB_HART};
        vecs[6] = '{12'h301, TB_MISA};
        addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                      12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0};

        n_rst = 0; raddr = 12'h301;
        irq_ext = 0; irq_tim = 0; irq_sw = 0;
        idle_inputs();
        model_reset();
        tick(); tick();
        chk("reset_rdata_misa", rdata, 32'h0);
        chk("reset_mtvec", o_mtvec, 32'h0);
        chk("reset_epc", o_epc, 32'h0);
        n_rst = 1;

        // Reset-state reads
        for (int i = 0; i < 7; i++) begin
            rd($sformatf("reset_read_%03h", vecs[i].addr), vecs[i].addr, vecs[i].exp);
            tick();
        end

        // Enables, then timer pending appears one cycle after the line
        we = 1; waddr = 12'h300; wdata = 32'h8; tick();
        waddr = 12'h304; wdata = 32'h880; tick();
        we = 0; irq_tim = 1;
        #1 chk("mip_timer_before_edge", {31'b0, o_mtip}, 32'h0);
        tick();
        chk("mip_timer_after_edge", {31'b0, o_mtip}, 32'h1);
        chk("mstatus_ie", {31'b0, o_mie}, 32'h1);
        chk("mie_timer", {31'b0, o_mtie}, 32'h1);
        chk("mie_ext", {31'b0, o_meie}, 32'h1);
        rd("mip_read", 12'h344, 32'h80);
        irq_tim = 0;

        // Trap entry colliding with a software mepc write
        we = 1; waddr = 12'h341; wdata = 32'h1234;
        set_cause = 1; set_epc = 1; set_mtval = 1; ie_clear = 1;
        ie_type = 1; cause = 4'd7; epc = 32'h8000_0102; mtval = 32'h0;
        tick();
        idle_inputs();
        rd("trap_mcause", 12'h342, 32'h8000_0007);
        rd("trap_mepc", 12'h341, 32'h8000_0100);
        rd("trap_mstatus", 12'h300, 32'h80);
        chk("trap_epc_o", o_epc, 32'h8000_0100);
        chk("trap_ie_o", {31'b0, o_mie}, 32'h0);
        ie_set = 1; tick(); ie_set = 0;
        rd("mret_mstatus", 12'h300, 32'h88);

        // clear and set together: clear wins
        ie_clear = 1; ie_set = 1; tick(); idle_inputs();
        rd("clear_beats_set", 12'h300, 32'h80);

        // mcycle carry into the high half, then a high write freezing the low half
        we = 1; waddr = 12'hB00; wdata = 32'hFFFF_FFFE; tick();
        waddr = 12'hB80; wdata = 32'h0; tick();
        we = 0;
        rd("mcycle_lo_hold", 12'hB00, 32'hFFFF_FFFE);
        rd("mcycleh_loaded", 12'hB80, 32'h0);
        tick(); tick();
        rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd("mcycle_wrap_hi", 12'hB80, 32'h1);
        raddr = 12'hB00; #1 lo_before = rdata;
        we = 1; waddr = 12'hB80; wdata = 32'h5; tick(); we = 0;
        rd("mcycleh_write_lo_holds", 12'hB00, lo_before);
        rd("mcycleh_write_hi", 12'hB80, 32'h5);

        // minstret: write on the 2nd retire pulse suppresses that increment
        instret = 1; tick();
        we = 1; waddr = 12'hB02; wdata = 32'h0; tick(); we = 0;
        tick(); instret = 0; tick();
        rd("minstret_lo", 12'hB02, 32'h1);
        rd("minstret_hi", 12'hB82, 32'h0);

        // mip and unknown addresses ignore writes
        we = 1; waddr = 12'h344; wdata = 32'h888; tick();
        waddr = 12'h301; wdata = 32'hFFFF_FFFF; tick();
        waddr = 12'h7C0; tick(); we = 0;
        rd("mip_ro", 12'h344, 32'h0);
        rd("misa_ro", 12'h301, TB_MISA);
        rd("unimpl_read", 12'h7C0, 32'h0);

        // mtvec bit 1 forced low
        we = 1; waddr = 12'h305; wdata = 32'h0000_1003; tick(); we = 0;
        chk("mtvec_bit1", o_mtvec, 32'h0000_1001);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            we        = ($urandom_range(0, 1) == 1);
            waddr     = addr_pool[$urandom_range(0, 14)];
            wdata     = $urandom;
            raddr     = addr_pool[$urandom_range(0, 14)];
            instret   = ($urandom_range(0, 1) == 1);
            set_cause = ($urandom_range(0, 9) == 0);
            set_epc   = ($urandom_range(0, 9) == 0);
            set_mtval = ($urandom_range(0, 9) == 0);
            ie_clear  = ($urandom_range(0, 9) == 0);
            ie_set    = ($urandom_range(0, 7) == 0);
            ie_type   = 1'($urandom_range(0, 1));
            cause     = 4'($urandom);
            epc       = $urandom;
            mtval     = $urandom;
            if ($urandom_range(0, 3) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(0, 3) == 0) irq_tim = ~irq_tim;
            if ($urandom_range(0, 3) == 0) irq_sw  = ~irq_sw;
            check_model();
            tick();
        end
        idle_inputs();
        check_model();

        // Asynchronous reset mid-cycle, then first increment after release
        #2 n_rst = 0; model_reset();
        raddr = 12'hB00;
        #1 chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_flags", {25'b0, o_mie, o_meie, o_mtie, o_msie, o_meip, o_mtip, o_msip}, 32'h0);
        chk("async_rst_mtvec", o_mtvec, 32'h0);
        irq_ext = 0; irq_tim = 0; irq_sw = 0;
        tick(); tick();
        #2 n_rst = 1;
        tick();
        rd("post_rst_mcycle", 12'hB00, 32'h1);
        rd("post_rst_mcycleh", 12'hB80, 32'h0);
        rd("post_rst_minstret", 12'hB02, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
